// File: rtl/dl_pkg.sv
// Shared definitions for the delay-line transfer scheduler: register
// select encodings, FSM states, requester identities and the default word length.
package dl_pkg;

  localparam int DL_BITS = 26;

  typedef enum logic [2:0] {
    SEL_PR  = 3'd0,
    SEL_MD  = 3'd1,
    SEL_MR  = 3'd2,
    SEL_ACC = 3'd3,
    SEL_STP = 3'd4,
    SEL_AI  = 3'd5,
    SEL_NU  = 3'd6,
    SEL_PQR = 3'd7
  } dl_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } dl_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } dl_req_e;

  // Selects STP..PQR live on line 31, PR..ACC on line 44.
  function automatic logic sel_line31(input logic [2:0] s);
    return s >= 3'(SEL_STP);
  endfunction

endpackage

// File: rtl/dl_scheduler_if.sv
// Interfaces: one requester's transfer handshake bundle, and the
// phase/bit timing bundle shared between the timing generator and the scheduler.
interface dl_scheduler_if #(
  parameter int BITS = dl_pkg::DL_BITS
);
  logic            req;
  logic [2:0]      sel;
  logic            we;
  logic [BITS-1:0] wdata;
  logic            gnt;

  modport master (output req, sel, we, wdata, input gnt);
  modport slave  (input req, sel, we, wdata, output gnt);
endinterface

interface dl_timing_if;
  logic [3:0] ph;
  logic [4:0] bitn;
  logic       frame_end;

  modport master (output ph, bitn, frame_end);
  modport slave  (input ph, bitn, frame_end);
endinterface

// File: rtl/dl_timing.sv
// Phase/bit-time generator: one-hot W,X,Y,Z phase, bit counter stepping on Z,
// and a strobe marking the last slot of the frame.
module dl_timing
  import dl_pkg::*;
#(
  parameter int BITS = DL_BITS
) (
  input  logic       clk,
  input  logic       rstn,
  dl_timing_if.master tim
);

  logic [3:0] r_ph;
  logic [4:0] r_bitn;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ph   <= 4'b0001;
      r_bitn <= '0;
    end else begin
      r_ph <= {r_ph[2:0], r_ph[3]};
      if (r_ph[3]) begin
        r_bitn <= (r_bitn == 5'(BITS - 1)) ? 5'd0 : r_bitn + 5'd1;
      end
    end
  end

  assign tim.ph        = r_ph;
  assign tim.bitn      = r_bitn;
  assign tim.frame_end = r_ph[3] && (r_bitn == 5'(BITS - 1));

endmodule

// File: rtl/dl_scheduler.sv
// Two-requester scheduler for a pair of recirculating delay lines; one word
// transfer per frame. Define DL_PARITY_EN to enable the read parity checker.
module dl_scheduler
  import dl_pkg::*;
#(
  parameter int BITS = DL_BITS
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_a,
  input  logic            req_b,
  input  logic [2:0]      sel_a,
  input  logic [2:0]      sel_b,
  input  logic            we_a,
  input  logic            we_b,
  input  logic [BITS-1:0] wdata_a,
  input  logic [BITS-1:0] wdata_b,
  output logic            gnt_a,
  output logic            gnt_b,
  output logic [BITS-1:0] rdata,
  output logic            rperr,
  input  logic            dl44_sa,
  input  logic            dl31_sa,
  output logic            dl44_g,
  output logic            dl31_g,
  output logic [3:0]      ph,
  output logic [4:0]      bitn,
  output logic            busy
);

  dl_timing_if u_tim_if ();

  dl_timing #(.BITS(BITS)) u_timing (
    .clk  (clk),
    .rstn (rstn),
    .tim  (u_tim_if)
  );

  dl_state_e       r_state;
  dl_state_e       w_state_next;
  dl_req_e         r_win;
  dl_req_e         w_winner;
  logic [2:0]      r_sel;
  logic            r_we;
  logic [BITS-1:0] r_wdata;
  logic [BITS-1:0] r_rd;
  logic [BITS-1:0] w_rd_next;
  logic [BITS-1:0] w_bit_hot;
  logic            r_g44;
  logic            r_g31;
  logic            r_gnt_a;
  logic            r_gnt_b;
  logic            w_latch;
  logic            w_done;
  logic            w_frame_end;
  logic [1:0]      w_phase;
  logic            w_line31;
  logic            w_slot_hit;
  logic            w_sensed;
  logic            w_wbit;
  logic            w_g44_next;
  logic            w_g31_next;

  assign ph          = u_tim_if.ph;
  assign bitn        = u_tim_if.bitn;
  assign w_frame_end = u_tim_if.frame_end;
  assign w_phase     = {ph[3] | ph[2], ph[3] | ph[1]};
  assign w_line31    = sel_line31(r_sel);
  assign w_slot_hit  = (r_state == ST_XFER) && (w_phase == r_sel[1:0]);
  assign w_sensed    = w_line31 ? dl31_sa : dl44_sa;

  genvar gi;
  generate
    for (gi = 0; gi < BITS; gi++) begin : g_bit
      assign w_bit_hot[gi] = (bitn == 5'(gi));
      assign w_rd_next[gi] = (w_slot_hit && w_bit_hot[gi]) ? w_sensed : r_rd[gi];
    end
  endgenerate

  assign w_wbit = |(r_wdata & w_bit_hot);

  // Every slot recirculates except the one a write transfer owns.
  assign w_g44_next = (w_slot_hit && !w_line31 && r_we) ? w_wbit : dl44_sa;
  assign w_g31_next = (w_slot_hit &&  w_line31 && r_we) ? w_wbit : dl31_sa;

  always_comb begin
    w_winner = REQ_A;
    if (req_a && req_b) begin
      w_winner = (r_win == REQ_A) ? REQ_B : REQ_A;
    end else if (req_b) begin
      w_winner = REQ_B;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_frame_end && (req_a || req_b)) begin
          w_state_next = ST_XFER;
          w_latch      = 1'b1;
        end
      end
      ST_XFER: begin
        if (w_frame_end) begin
          w_state_next = ST_DONE;
          w_done       = 1'b1;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // r_win doubles as round-robin history: the last winner loses the next tie.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_win   <= REQ_B;
      r_sel   <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_g44   <= 1'b0;
      r_g31   <= 1'b0;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_rd    <= w_rd_next;
      r_g44   <= w_g44_next;
      r_g31   <= w_g31_next;
      r_gnt_a <= w_done && (r_win == REQ_A);
      r_gnt_b <= w_done && (r_win == REQ_B);
      if (w_latch) begin
        r_win   <= w_winner;
        r_sel   <= (w_winner == REQ_B) ? sel_b   : sel_a;
        r_we    <= (w_winner == REQ_B) ? we_b    : we_a;
        r_wdata <= (w_winner == REQ_B) ? wdata_b : wdata_a;
      end
    end
  end

`ifdef DL_PARITY_EN
  logic r_rperr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rperr <= 1'b0;
    end else begin
      r_rperr <= w_done && ~^w_rd_next;
    end
  end

  assign rperr = r_rperr;
`else
  assign rperr = 1'b0;
`endif

  assign gnt_a  = r_gnt_a;
  assign gnt_b  = r_gnt_b;
  assign rdata  = r_rd;
  assign dl44_g = r_g44;
  assign dl31_g = r_g31;
  assign busy   = (r_state != ST_IDLE);

endmodule

// File: doc/dl_scheduler.md
DL_SCHEDULER -- requirements
Module: dl_scheduler

Interface
REQ-001 SHALL have parameter BITS, default 26, word length in bit-times per delay-line frame (range 4..32).
REQ-002 SHALL have port clk  input  1  phase-slot clock, all state on rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports req_a, req_b  input  1  transfer requests; requester A = arithmetic unit, B = I/O.
REQ-005 SHALL have ports sel_a, sel_b  input  3  target register; 0-3 = PR,MD,MR,ACC on line 44, 4-7 = STP,AI,NU,PQR on line 31.
REQ-006 SHALL have ports we_a, we_b  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports wdata_a, wdata_b  input  BITS  write words, LSB shifted first.
REQ-008 SHALL have ports gnt_a, gnt_b  output  1  one-cycle completion pulses.
REQ-009 SHALL have port rdata  output  BITS  read word, valid while gnt_a or gnt_b is high.
REQ-010 SHALL have port rperr  output  1  read parity error, valid with a grant.
REQ-011 SHALL have ports dl44_sa, dl31_sa  input  1  sense-amp outputs of the two delay lines.
REQ-012 SHALL have ports dl44_g, dl31_g  output  1  registered gate bits driven into the line drivers.
REQ-013 SHALL have ports ph  output  4  one-hot phase W,X,Y,Z (bit 0 = W) and bitn  output  5  bit-time counter.
REQ-014 SHALL have port busy  output  1  high while a transfer is latched.

Function
REQ-015 SHALL advance the phase counter once per clk W->X->Y->Z->W, and increment bitn on Z, wrapping BITS-1 -> 0; one frame = 4*BITS clocks.
REQ-016 SHALL treat slot (bitn=k, phase=p) as bit k of register p on each line; the line delays exactly one frame.
REQ-017 SHALL in every slot drive each gate with its sensed bit (recirculate), except the single slot owned by a write transfer.
REQ-018 SHALL use states IDLE, XFER, DONE.
REQ-019 SHALL arbitrate only in slot (BITS-1, Z): IDLE with any request -> XFER at the frame start, latching winner, sel, we, and wdata.
REQ-020 SHALL arbitrate round-robin; after reset A has priority; the last granted requester loses the next tie.
REQ-021 SHALL in XFER, at phase sel[1:0] on line sel[2], shift the sensed bit into the read register at index bitn, and on write drive wdata[bitn] in place of recirculation.
REQ-022 SHALL go XFER -> DONE after slot (BITS-1, Z) and assert the winner's gnt and rdata for exactly that DONE cycle; DONE -> IDLE next clock.
REQ-023 SHALL, for a write, return the pre-write contents in rdata.
REQ-024 SHALL not arbitrate in DONE; a request pending then is served from the next frame boundary, so at most one transfer completes per frame.
REQ-025 SHALL require requesters to hold req/sel/we/wdata until their gnt; a request dropped before latch is ignored, and one dropped after latch still completes.
REQ-026 SHALL drive busy high in XFER and DONE.

Reset
REQ-027 SHALL on rstn low immediately set phase to W (ph=0001), bitn=0, state IDLE, gates 0, gnt 0, rdata 0, rperr 0, priority to A.
REQ-028 SHALL abort a transfer interrupted by reset without a grant; line contents are undefined after reset.

Configuration
REQ-029 SHALL with DL_PARITY_EN defined set rperr = 1 when the read word (bit BITS-1 = parity) has even parity; without it, rperr is tied 0 and the checker is absent.

Structure
REQ-030 SHALL place the register-select encodings (PR..PQR), state enumeration, and default BITS in shared package dl_pkg.
REQ-031 SHALL implement the phase/bit timing generator as sub-module dl_timing (outputs ph, bitn, and a frame-end strobe).

Verification
REQ-032 SHALL pass: write A sel=3 (ACC) 0x2AAAAAA, then read B sel=3 -> second gnt_b rdata=0x2AAAAAA, with bench modelling each line as a 104-clock FIFO.
REQ-033 SHALL pass: req_a and req_b both held from reset -> grants alternate A,B,A,B on frame boundaries (every 208 clocks after the first).
REQ-034 SHALL pass: write sel=4 (STP)=0x1234567 -> read of sel=0..3 and 5..7 returns prior values unchanged.
REQ-035 SHALL pass: rstn low at bitn=10 during a write -> no gnt, ph=0001, bitn=0 immediately; next request completes normally.
REQ-036 SHALL pass with DL_PARITY_EN: stored word 0x0000001 -> rperr=0; 0x0000003 -> rperr=1; without the macro rperr=0 in both cases.
